// File: rtl/qpmm_canon_reducer.sv
// qpmm_canon_reducer: limb-serial conditional subtraction of p, reducing a redundant QPMM result Z < 4p to [0, p).
module qpmm_canon_reducer #(
    parameter int            ZW      = 272,
    parameter int            LIMB_W  = 16,
    parameter int            MAX_SUB = 3,
    parameter logic [ZW-1:0] MOD     = 272'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [ZW-1:0] in_z,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [ZW-1:0] out_z,
    output logic          out_err
);
    localparam int N_LIMBS = ZW / LIMB_W;
    localparam int LC_W    = $clog2(N_LIMBS);
    localparam int SC_W    = $clog2(MAX_SUB + 1);

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    state_t            state_q, state_d;
    logic [ZW-1:0]     acc_q, acc_d, diff_q, diff_d, diff_full;
    logic [LC_W-1:0]   limb_cnt_q, limb_cnt_d;
    logic [SC_W-1:0]   sub_cnt_q, sub_cnt_d;
    logic              borrow_q, borrow_d;
    logic              out_err_q, out_err_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic [LIMB_W-1:0] a_limb, m_limb, d_limb;
    logic              b_out, last;

    always_comb begin
        a_limb = acc_q[limb_cnt_q*LIMB_W +: LIMB_W];
        m_limb = MOD[limb_cnt_q*LIMB_W +: LIMB_W];
        {b_out, d_limb} = {1'b0, a_limb} - {1'b0, m_limb} - {{LIMB_W{1'b0}}, borrow_q};
        diff_full = diff_q;
        diff_full[limb_cnt_q*LIMB_W +: LIMB_W] = d_limb;
        last = limb_cnt_q == LC_W'(N_LIMBS - 1);
        state_d     = state_q;
        acc_d       = acc_q;
        diff_d      = diff_q;
        limb_cnt_d  = limb_cnt_q;
        sub_cnt_d   = sub_cnt_q;
        borrow_d    = borrow_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: if (in_valid && in_ready_q) begin
                acc_d      = in_z;
                limb_cnt_d = '0;
                sub_cnt_d  = '0;
                borrow_d   = 1'b0;
                state_d    = SUB;
            end
            SUB: begin
                diff_d     = diff_full;
                borrow_d   = last ? 1'b0 : b_out;
                limb_cnt_d = last ? '0 : limb_cnt_q + 1'b1;
                if (last) begin
                    // A final borrow means acc < p; otherwise subtract again until the pass budget runs out.
                    if (b_out) begin
                        out_err_d = 1'b0;
                        state_d   = DONE;
                    end else if (sub_cnt_q < SC_W'(MAX_SUB)) begin
                        acc_d     = diff_full;
                        sub_cnt_d = sub_cnt_q + 1'b1;
                    end else begin
                        out_err_d = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                out_valid_d = ~(out_valid_q && out_ready);
                state_d     = (out_valid_q && out_ready) ? IDLE : DONE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = state_d == IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            diff_q      <= '0;
            limb_cnt_q  <= '0;
            sub_cnt_q   <= '0;
            borrow_q    <= 1'b0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            diff_q      <= diff_d;
            limb_cnt_q  <= limb_cnt_d;
            sub_cnt_q   <= sub_cnt_d;
            borrow_q    <= borrow_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_z     = acc_q;
    assign out_err   = out_err_q;
endmodule

// File: tb/tb_qpmm_canon_reducer.sv
// tb_qpmm_canon_reducer: directed and random checks of the canonical reducer against a plain-arithmetic model.
module tb_qpmm_canon_reducer;
    localparam int ZW = 272;
    localparam logic [ZW-1:0] P = 272'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

    logic          clk = 1'b0, rstn = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [ZW-1:0] in_z = '0;
    logic          in_ready, out_valid, out_err;
    logic [ZW-1:0] out_z;
    int            checks = 0, errors = 0;

    qpmm_canon_reducer dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [ZW-1:0] obs, input logic [ZW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: subtract p while it fits, at most three times; one extra pass detects the borrow.
    function automatic void model(input logic [ZW-1:0] z, output logic [ZW-1:0] r, output logic e, output int lat);
        int k = 0;
        r = z;
        while (k < 3 && r >= P) begin
            r = r - P;
            k++;
        end
        e = r >= P;
        lat = (k + 1) * 17 + 1;
    endfunction

    task automatic issue(input logic [ZW-1:0] z, output int lat, output bit ready_low);
        int w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        in_valid = 1'b1;
        in_z = z;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        ready_low = 1'b1;
        do begin
            if (in_ready) ready_low = 1'b0;
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 200);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".ready_after"}, ZW'(in_ready), ZW'(1));
        check({tag, ".valid_after"}, ZW'(out_valid), ZW'(0));
    endtask

    task automatic txn(input logic [ZW-1:0] z, input string tag, input int gap, output logic [ZW-1:0] oz);
        logic [ZW-1:0] er;
        logic ee;
        int el, lat;
        bit rl;
        model(z, er, ee, el);
        issue(z, lat, rl);
        check({tag, ".lat"}, ZW'(lat), ZW'(el));
        check({tag, ".z"}, out_z, er);
        check({tag, ".err"}, ZW'(out_err), ZW'(ee));
        check({tag, ".ready_low"}, ZW'(rl), ZW'(1));
        oz = out_z;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        if (gap > 0) check({tag, ".hold"}, out_z, oz);
        drain(tag);
    endtask

    initial begin
        logic [ZW-1:0] oz, rnd, r;
        int lat;
        bit rl;
        #12;
        check("rst.ready", ZW'(in_ready), ZW'(1));
        check("rst.valid", ZW'(out_valid), ZW'(0));
        check("rst.z", out_z, '0);
        check("rst.err", ZW'(out_err), ZW'(0));
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;

        txn('0, "zero", 0, oz);
        txn(P - 1, "pm1", 0, oz);
        txn(P, "p", 0, oz);
        txn(3 * P + 5, "3p5", 0, oz);
        txn(4 * P, "4p", 0, oz);
        txn(ZW'(1) << 271, "top", 1, oz);

        // Backpressure: outputs frozen, input pulses ignored while waiting.
        issue(P + 7, lat, rl);
        check("bp.lat", ZW'(lat), ZW'(35));
        check("bp.z", out_z, ZW'(7));
        for (int i = 0; i < 7; i++) begin
            in_valid = i[0];
            in_z = {8{$urandom}};
            @(posedge clk); #1;
            check("bp.valid", ZW'(out_valid), ZW'(1));
            check("bp.zhold", out_z, ZW'(7));
            check("bp.ready", ZW'(in_ready), ZW'(0));
        end
        in_valid = 1'b0;
        drain("bp");
        @(posedge clk); #1;
        check("bp.no_phantom", ZW'(out_valid), ZW'(0));

        // Reset at limb 9 of the second pass.
        in_valid = 1'b1;
        in_z = 3 * P + 2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (17 + 9) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        check("abort.ready", ZW'(in_ready), ZW'(1));
        check("abort.valid", ZW'(out_valid), ZW'(0));
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        txn(2 * P + 1, "after_abort", 0, oz);
        check("after_abort.one", oz, ZW'(1));

        for (int n = 0; n < 800; n++) begin
            rnd = {16'h0, {8{$urandom}}};
            r = rnd % P;
            txn(ZW'($urandom_range(0, 3)) * P + r, "rand", $urandom_range(0, 3), oz);
            check("rand.r", oz, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
